ahb_mux_master_dphase: RTL and testbench

AHB_MUX_MASTER_DPHASE -- requirements
Module: ahb_mux_master_dphase

---
 rtl/ahb_mux_master_dphase_if.sv | 29 ++
 rtl/ahb_mux_master_dphase.sv | 101 ++++++++++
 tb/tb_ahb_mux_master_dphase.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_mux_master_dphase_if.sv
// Bus bundle between the address decoder / slaves and the data-phase response mux.
// The slave modport is the mux's view; the master modport is the surrounding fabric's view.
interface ahb_mux_master_dphase_if #(
    parameter int CHANNEL_NUM = 2,
    parameter int DATA_W      = 32,
    parameter int PAYLOAD     = DATA_W + 2
);
    logic [CHANNEL_NUM-1:0][PAYLOAD-1:0] payload_in;
    logic [CHANNEL_NUM-1:0]              sel_addr;
    logic                                trans_valid;
    logic [PAYLOAD-1:0]                  payload_out;
    logic [CHANNEL_NUM-1:0]              dsel;

    modport slave (
        input  payload_in,
        input  sel_addr,
        input  trans_valid,
        output payload_out,
        output dsel
    );

    modport master (
        output payload_in,
        output sel_addr,
        output trans_valid,
        input  payload_out,
        input  dsel
    );
endinterface

// File: rtl/ahb_mux_master_dphase.sv
// AHB data-phase response mux: registers the address-phase slave select and routes the
// selected slave's {hrdata, hreadyout, hresp} back, answering decode errors itself.
module ahb_mux_master_dphase #(
    parameter int CHANNEL_NUM = 2,
    parameter int DATA_W      = 32,
    parameter int PAYLOAD     = DATA_W + 2,
    parameter int CNT_W       = 8
) (
    input  logic                   hclk,
    input  logic                   hreset,
    ahb_mux_master_dphase_if.slave bus,
    output logic                   err_pulse,
    output logic [CNT_W-1:0]       err_cnt,
    output logic [1:0]             state_dbg
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DATA = 2'd1;
    localparam logic [1:0] ST_ERR1 = 2'd2;
    localparam logic [1:0] ST_ERR2 = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [CHANNEL_NUM-1:0] dsel_q, dsel_d;
    logic [CNT_W-1:0]       err_cnt_q, err_cnt_d;

    logic [PAYLOAD-1:0]     payload_mux;
    logic [PAYLOAD-1:0]     payload_out_c;
    logic [CHANNEL_NUM-1:0] sel_minus_one;
    logic                   sel_onehot;
    logic                   hready_mux;
    logic                   accept;
    logic                   decode_err;

    // dsel_q is one-hot or zero, so an AND-OR mux is enough.
    always_comb begin
        payload_mux = '0;
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            if (dsel_q[i]) begin
                payload_mux = payload_mux | bus.payload_in[i];
            end
        end
    end

    always_comb begin
        payload_out_c = {{DATA_W{1'b0}}, 1'b1, 1'b0};
        case (state_q)
            ST_IDLE: payload_out_c = {{DATA_W{1'b0}}, 1'b1, 1'b0};
            ST_DATA: payload_out_c = payload_mux;
            ST_ERR1: payload_out_c = {{DATA_W{1'b0}}, 1'b0, 1'b1};
            ST_ERR2: payload_out_c = {{DATA_W{1'b0}}, 1'b1, 1'b1};
            default: payload_out_c = {{DATA_W{1'b0}}, 1'b1, 1'b0};
        endcase
    end

    assign sel_minus_one = bus.sel_addr - CHANNEL_NUM'(1);
    assign sel_onehot    = (bus.sel_addr != '0) && ((bus.sel_addr & sel_minus_one) == '0);
    assign hready_mux    = payload_out_c[1];
    assign accept        = hready_mux && (state_q != ST_ERR1);
    assign decode_err    = accept && bus.trans_valid && !sel_onehot;

    always_comb begin
        state_d   = state_q;
        dsel_d    = dsel_q;
        err_cnt_d = err_cnt_q;
        // ERR1 is the wait-state half of the two-cycle ERROR response; it never accepts.
        if (state_q == ST_ERR1) begin
            state_d = ST_ERR2;
        end else if (accept) begin
            if (!bus.trans_valid) begin
                state_d = ST_IDLE;
                dsel_d  = '0;
            end else if (sel_onehot) begin
                state_d = ST_DATA;
                dsel_d  = bus.sel_addr;
            end else begin
                state_d = ST_ERR1;
                dsel_d  = '0;
                if (err_cnt_q != {CNT_W{1'b1}}) begin
                    err_cnt_d = err_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q   <= ST_IDLE;
            dsel_q    <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            dsel_q    <= dsel_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.payload_out = payload_out_c;
    assign bus.dsel        = dsel_q;
    assign err_pulse       = decode_err && !hreset;
    assign err_cnt         = err_cnt_q;
    assign state_dbg       = state_q;
endmodule

// File: tb/tb_ahb_mux_master_dphase.sv
// Directed bench for the AHB data-phase response mux: reset, routing, wait states,
// back-to-back switching, decode errors with counter saturation, and reset mid-transfer.
module tb_ahb_mux_master_dphase;
  localparam int CH = 2;
  localparam int DW = 32;
  localparam int PW = DW + 2;
  localparam int CW = 2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_ERR1 = 2'd2;
  localparam logic [1:0] S_ERR2 = 2'd3;

  logic          clk = 1'b0;
  logic          hreset;
  logic          err_pulse;
  logic [CW-1:0] err_cnt;
  logic [1:0]    state_dbg;
  int            errors = 0;
  int            checks = 0;

  ahb_mux_master_dphase_if #(.CHANNEL_NUM(CH), .DATA_W(DW), .PAYLOAD(PW)) bus ();

  ahb_mux_master_dphase #(.CHANNEL_NUM(CH), .DATA_W(DW), .PAYLOAD(PW), .CNT_W(CW)) dut (
    .hclk      (clk),
    .hreset    (hreset),
    .bus       (bus),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] mk(input logic [DW-1:0] d, input logic rdy, input logic resp);
    return {d, rdy, resp};
  endfunction

  // Advance one rising edge, then settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    hreset = 1'b1;
    bus.trans_valid = 1'b1;
    bus.sel_addr = 2'b11;
    bus.payload_in[0] = mk(32'h1111_1111, 1'b0, 1'b0);
    bus.payload_in[1] = mk(32'h2222_2222, 1'b0, 1'b0);
    step();
    step();
    checks++;
    if (bus.payload_out !== mk(32'h0, 1'b1, 1'b0)) begin
      errors++; $display("FAIL reset_payload: got %h exp %h", bus.payload_out, mk(32'h0, 1'b1, 1'b0));
    end
    checks++;
    if (err_pulse !== 1'b0) begin
      errors++; $display("FAIL reset_no_pulse: got %b exp 0", err_pulse);
    end
    checks++;
    if (err_cnt !== 2'd0 || bus.dsel !== 2'b00) begin
      errors++; $display("FAIL reset_regs: got cnt=%0d dsel=%b exp cnt=0 dsel=00", err_cnt, bus.dsel);
    end
    hreset = 1'b0;
    bus.trans_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (bus.payload_out !== mk(32'h0, 1'b1, 1'b0) || bus.dsel !== 2'b00 || err_cnt !== 2'd0) begin
        errors++;
        $display("FAIL idle_cycle%0d: got payload=%h dsel=%b cnt=%0d exp payload=%h dsel=00 cnt=0",
                 k, bus.payload_out, bus.dsel, err_cnt, mk(32'h0, 1'b1, 1'b0));
      end
    end
  endtask

  task automatic test_single_read();
    bus.payload_in[0] = mk(32'h1234_5678, 1'b1, 1'b0);
    bus.payload_in[1] = mk(32'hDEAD_BEEF, 1'b1, 1'b0);
    bus.trans_valid = 1'b1;
    bus.sel_addr = 2'b10;
    #1;
    checks++;
    if (err_pulse !== 1'b0) begin
      errors++; $display("FAIL read_no_pulse: got %b exp 0", err_pulse);
    end
    step();
    bus.trans_valid = 1'b0;
    #1;
    checks++;
    if (bus.dsel !== 2'b10 || state_dbg !== S_DATA) begin
      errors++; $display("FAIL read_dsel: got dsel=%b state=%0d exp dsel=10 state=%0d", bus.dsel, state_dbg, S_DATA);
    end
    checks++;
    if (bus.payload_out !== mk(32'hDEAD_BEEF, 1'b1, 1'b0)) begin
      errors++; $display("FAIL read_payload: got %h exp %h", bus.payload_out, mk(32'hDEAD_BEEF, 1'b1, 1'b0));
    end
    step();
    checks++;
    if (state_dbg !== S_IDLE || bus.dsel !== 2'b00) begin
      errors++; $display("FAIL read_return_idle: got state=%0d dsel=%b exp state=0 dsel=00", state_dbg, bus.dsel);
    end
  endtask

  task automatic test_wait_state();
    bus.trans_valid = 1'b1;
    bus.sel_addr = 2'b10;
    step();
    bus.payload_in[1] = mk(32'hAAAA_0000, 1'b0, 1'b0);
    bus.sel_addr = 2'b01;
    #1;
    checks++;
    if (bus.payload_out !== mk(32'hAAAA_0000, 1'b0, 1'b0)) begin
      errors++; $display("FAIL wait_passthru: got %h exp %h", bus.payload_out, mk(32'hAAAA_0000, 1'b0, 1'b0));
    end
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (bus.dsel !== 2'b10 || state_dbg !== S_DATA) begin
        errors++; $display("FAIL wait_hold%0d: got dsel=%b state=%0d exp dsel=10 state=1", k, bus.dsel, state_dbg);
      end
    end
    bus.payload_in[1] = mk(32'hCAFE_F00D, 1'b1, 1'b0);
    bus.payload_in[0] = mk(32'h0101_0101, 1'b1, 1'b0);
    step();
    checks++;
    if (bus.dsel !== 2'b01 || bus.payload_out !== mk(32'h0101_0101, 1'b1, 1'b0)) begin
      errors++; $display("FAIL wait_release: got dsel=%b payload=%h exp dsel=01 payload=%h",
                         bus.dsel, bus.payload_out, mk(32'h0101_0101, 1'b1, 1'b0));
    end
  endtask

  task automatic test_back_to_back();
    bus.trans_valid = 1'b1;
    bus.sel_addr = 2'b10;
    bus.payload_in[1] = mk(32'h5A5A_5A5A, 1'b1, 1'b0);
    step();
    checks++;
    if (bus.dsel !== 2'b10 || bus.payload_out !== mk(32'h5A5A_5A5A, 1'b1, 1'b0)) begin
      errors++; $display("FAIL b2b_to_s1: got dsel=%b payload=%h exp dsel=10 payload=%h",
                         bus.dsel, bus.payload_out, mk(32'h5A5A_5A5A, 1'b1, 1'b0));
    end
    bus.sel_addr = 2'b01;
    bus.payload_in[0] = mk(32'h0000_0000, 1'b0, 1'b1);
    step();
    checks++;
    if (bus.dsel !== 2'b01 || bus.payload_out !== mk(32'h0000_0000, 1'b0, 1'b1)) begin
      errors++; $display("FAIL b2b_slave_err1: got dsel=%b payload=%h exp dsel=01 payload=%h",
                         bus.dsel, bus.payload_out, mk(32'h0, 1'b0, 1'b1));
    end
    bus.payload_in[0] = mk(32'h0000_0000, 1'b1, 1'b1);
    bus.trans_valid = 1'b0;
    #1;
    checks++;
    if (bus.payload_out !== mk(32'h0000_0000, 1'b1, 1'b1) || state_dbg !== S_DATA) begin
      errors++; $display("FAIL b2b_slave_err2: got payload=%h state=%0d exp payload=%h state=1",
                         bus.payload_out, state_dbg, mk(32'h0, 1'b1, 1'b1));
    end
    step();
  endtask

  task automatic test_decode_error();
    hreset = 1'b1;
    step();
    hreset = 1'b0;
    bus.trans_valid = 1'b1;
    bus.sel_addr = 2'b11;
    #1;
    checks++;
    if (err_pulse !== 1'b1) begin
      errors++; $display("FAIL derr_pulse: got %b exp 1", err_pulse);
    end
    step();
    checks++;
    if (state_dbg !== S_ERR1 || bus.payload_out !== mk(32'h0, 1'b0, 1'b1) || err_cnt !== 2'd1) begin
      errors++; $display("FAIL derr_err1: got state=%0d payload=%h cnt=%0d exp state=2 payload=%h cnt=1",
                         state_dbg, bus.payload_out, err_cnt, mk(32'h0, 1'b0, 1'b1));
    end
    checks++;
    if (err_pulse !== 1'b0 || bus.dsel !== 2'b00) begin
      errors++; $display("FAIL derr_err1_noaccept: got pulse=%b dsel=%b exp pulse=0 dsel=00", err_pulse, bus.dsel);
    end
    bus.sel_addr = 2'b01;
    step();
    checks++;
    if (state_dbg !== S_ERR2 || bus.payload_out !== mk(32'h0, 1'b1, 1'b1) || err_cnt !== 2'd1) begin
      errors++; $display("FAIL derr_err2: got state=%0d payload=%h cnt=%0d exp state=3 payload=%h cnt=1",
                         state_dbg, bus.payload_out, err_cnt, mk(32'h0, 1'b1, 1'b1));
    end
    bus.payload_in[0] = mk(32'h7777_7777, 1'b1, 1'b0);
    step();
    checks++;
    if (state_dbg !== S_DATA || bus.dsel !== 2'b01 || bus.payload_out !== mk(32'h7777_7777, 1'b1, 1'b0)) begin
      errors++; $display("FAIL derr_recover: got state=%0d dsel=%b payload=%h exp state=1 dsel=01 payload=%h",
                         state_dbg, bus.dsel, bus.payload_out, mk(32'h7777_7777, 1'b1, 1'b0));
    end
  endtask

  task automatic test_err_saturate();
    logic [CW-1:0] exp_cnt [5];
    logic [CH-1:0] bad_sel [2];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    bad_sel = '{2'b00, 2'b11};
    hreset = 1'b1;
    step();
    hreset = 1'b0;
    bus.trans_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.sel_addr = bad_sel[k % 2];
      #1;
      checks++;
      if (err_pulse !== 1'b1) begin
        errors++; $display("FAIL sat_pulse%0d: got %b exp 1", k, err_pulse);
      end
      step();
      checks++;
      if (state_dbg !== S_ERR1 || err_cnt !== exp_cnt[k]) begin
        errors++; $display("FAIL sat_cnt%0d: got state=%0d cnt=%0d exp state=2 cnt=%0d", k, state_dbg, err_cnt, exp_cnt[k]);
      end
      step();
      checks++;
      if (state_dbg !== S_ERR2 || bus.payload_out !== mk(32'h0, 1'b1, 1'b1)) begin
        errors++; $display("FAIL sat_err2_%0d: got state=%0d payload=%h exp state=3 payload=%h",
                           k, state_dbg, bus.payload_out, mk(32'h0, 1'b1, 1'b1));
      end
    end
  endtask

  task automatic test_reset_mid_transfer();
    // Reset while in ERR1
    bus.trans_valid = 1'b1;
    bus.sel_addr = 2'b11;
    step();
    hreset = 1'b1;
    #1;
    checks++;
    if (err_pulse !== 1'b0) begin
      errors++; $display("FAIL rst_err1_pulse: got %b exp 0", err_pulse);
    end
    step();
    checks++;
    if (bus.payload_out !== mk(32'h0, 1'b1, 1'b0) || bus.dsel !== 2'b00 || err_cnt !== 2'd0 || state_dbg !== S_IDLE) begin
      errors++; $display("FAIL rst_err1: got payload=%h dsel=%b cnt=%0d state=%0d exp payload=%h dsel=00 cnt=0 state=0",
                         bus.payload_out, bus.dsel, err_cnt, state_dbg, mk(32'h0, 1'b1, 1'b0));
    end
    // Reset while DATA is stalled by the slave
    hreset = 1'b0;
    bus.sel_addr = 2'b10;
    bus.payload_in[1] = mk(32'h9999_9999, 1'b0, 1'b0);
    step();
    checks++;
    if (state_dbg !== S_DATA || bus.payload_out !== mk(32'h9999_9999, 1'b0, 1'b0)) begin
      errors++; $display("FAIL rst_data_setup: got state=%0d payload=%h exp state=1 payload=%h",
                         state_dbg, bus.payload_out, mk(32'h9999_9999, 1'b0, 1'b0));
    end
    hreset = 1'b1;
    step();
    checks++;
    if (state_dbg !== S_IDLE || bus.dsel !== 2'b00 || bus.payload_out !== mk(32'h0, 1'b1, 1'b0)) begin
      errors++; $display("FAIL rst_data_stall: got state=%0d dsel=%b payload=%h exp state=0 dsel=00 payload=%h",
                         state_dbg, bus.dsel, bus.payload_out, mk(32'h0, 1'b1, 1'b0));
    end
    hreset = 1'b0;
    bus.trans_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_wait_state();
    test_back_to_back();
    test_decode_error();
    test_err_saturate();
    test_reset_mid_transfer();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
